sm3_expnd_core: RTL

- Downstream neighbour of the SM3 padding stage, upstream of the compression stage.
- Collects the 16 padded 32-bit words of each 512-bit block.
- Produces the 64 expanded word pairs (W_j, W'_j = W_j ^ W_{j+4}), one pair per round, with a ready handshake.
- Propagates the message-last flag to round 63 of the final block.

---
 rtl/sm3_expnd_core.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sm3_expnd_core.sv
// rtl/sm3_expnd_core.sv - SM3 message expansion: 16-word load, 64 (W_j, W'_j) pairs per block
module sm3_expnd_core #(
    parameter int WD      = 32,
    parameter int RND_NUM = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WD-1:0] pad_otpt_d_i,
    input  logic          pad_otpt_vld_i,
    input  logic          pad_otpt_lst_i,
    output logic          pad_otpt_ena_o,
    output logic [WD-1:0] expnd_otpt_wj_o,
    output logic [WD-1:0] expnd_otpt_wjj_o,
    output logic [5:0]    expnd_otpt_rnd_o,
    output logic          expnd_otpt_vld_o,
    output logic          expnd_otpt_lst_o,
    input  logic          expnd_otpt_rdy_i
);

    typedef enum logic {LOAD, RUN} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [5:0]    rnd_q, rnd_d;
    logic          lst_q, lst_d;
    logic [WD-1:0] wbuf_q [16];
    logic [WD-1:0] wbuf_d [16];

    logic          pad_xfer;
    logic          out_xfer;
    logic          last_rnd;
    logic [WD-1:0] w_new;
    logic [WD-1:0] p1_in;

    function automatic logic [WD-1:0] rol(input logic [WD-1:0] x, input int unsigned n);
        return (x << n) | (x >> (WD - n));
    endfunction

    function automatic logic [WD-1:0] p1(input logic [WD-1:0] x);
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

    assign pad_xfer = pad_otpt_vld_i && pad_otpt_ena_o;
    assign out_xfer = expnd_otpt_vld_o && expnd_otpt_rdy_i;
    assign last_rnd = (rnd_q == 6'(RND_NUM - 1));

    // wbuf_q[0..15] holds W_j..W_{j+15}; this produces W_{j+16}
    assign p1_in = wbuf_q[0] ^ wbuf_q[7] ^ rol(wbuf_q[13], 15);
    assign w_new = p1(p1_in) ^ rol(wbuf_q[3], 7) ^ wbuf_q[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= 4'd0;
            rnd_q   <= 6'd0;
            lst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            lst_q   <= lst_d;
        end
    end

    // Buffer contents are don't-care after reset; outputs are gated by state
    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            wbuf_q[i] <= wbuf_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (pad_xfer && cnt_q == 4'd15) state_d = RUN;
            RUN:     if (out_xfer && last_rnd) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        rnd_d = rnd_q;
        lst_d = lst_q;
        for (int i = 0; i < 16; i++) begin
            wbuf_d[i] = wbuf_q[i];
        end
        if (state_q == LOAD && pad_xfer) begin
            for (int i = 0; i < 15; i++) begin
                wbuf_d[i] = wbuf_q[i + 1];
            end
            wbuf_d[15] = pad_otpt_d_i;
            cnt_d      = cnt_q + 4'd1;
            if (cnt_q == 4'd15) lst_d = pad_otpt_lst_i;
        end else if (state_q == RUN && out_xfer) begin
            if (last_rnd) begin
                rnd_d = 6'd0;
                lst_d = 1'b0;
            end else begin
                for (int i = 0; i < 15; i++) begin
                    wbuf_d[i] = wbuf_q[i + 1];
                end
                wbuf_d[15] = w_new;
                rnd_d      = rnd_q + 6'd1;
            end
        end
    end

    always_comb begin
        pad_otpt_ena_o   = (state_q == LOAD);
        expnd_otpt_vld_o = (state_q == RUN);
        expnd_otpt_wj_o  = '0;
        expnd_otpt_wjj_o = '0;
        if (state_q == RUN) begin
            expnd_otpt_wj_o  = wbuf_q[0];
            expnd_otpt_wjj_o = wbuf_q[0] ^ wbuf_q[4];
        end
        expnd_otpt_rnd_o = rnd_q;
        expnd_otpt_lst_o = (state_q == RUN) && last_rnd && lst_q;
    end

endmodule
